bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock.
- Sits directly upstream of the per-digit seven-segment decoders and feeds them score/timer values.
- Produces DIGITS packed BCD nibbles with optional leading-zero blanking. Blanked digits use code 4'hF, which the decoder renders as all segments off.

Parameters:
- BIN_W, 11, width of binary input; 1 <= BIN_W <= 4*DIGITS
- DIGITS, 4, number of BCD digits produced
- LZ_BLANK, 1, 1 = replace leading-zero digits with 4'hF; digit 0 is never blanked

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request conversion; sampled only in IDLE
- bin_in  input  BIN_W  binary value; captured on the accepted start edge only
- busy  output  1  high from the edge after start is accepted until the done edge
- done  output  1  one-cycle pulse; bcd_out/overflow valid from this cycle on
- bcd_out  output  4*DIGITS  packed digits; [3:0] = ones; held until the next done
- overflow  output  1  captured bin_in >= 10**DIGITS; held with bcd_out

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, overflow=0.
  - bcd_out=0, or {4'hF,...,4'hF,4'h0} when LZ_BLANK=1.
- States:
  - IDLE -> SHIFT when start=1. At that edge (E0): load shift register {BCD=0, bin_in}, bit counter=0, latch overflow compare, busy<=1.
  - SHIFT: each edge applies add-3 to every BCD nibble >= 5, then shifts the whole register left 1 and increments the counter. After BIN_W shifts (edge E_BIN_W), go to FINISH.
  - FINISH -> IDLE at edge E_{BIN_W+1}: bcd_out <= result (blanked/clamped), overflow updated, done<=1, busy<=0.
- Latency:
  - done is high exactly in the cycle after E_{BIN_W+1}, i.e. BIN_W+1 clocks after start is sampled.
  - done deasserts at the next edge.
- Handshake:
  - start while busy (SHIFT/FINISH) is ignored; no queueing.
  - start high in the done cycle (state IDLE) is accepted, giving back-to-back throughput of one result per BIN_W+2 cycles.
  - bin_in changes after E0 have no effect.
- Overflow: if the latched flag is set, bcd_out = all digits 4'h9 and overflow=1. No blanking applies, since the top digit is 9.
- Blanking (LZ_BLANK=1):
  - Digit i (i>=1) is replaced with 4'hF iff it and all higher digits are 0.
  - Value 0 displays as F..F0.
- Reset mid-conversion: immediate return to reset values; no done pulse; the partial result is discarded.
- Width rules:
  - Internal shift register is 4*DIGITS+BIN_W bits.
  - Overflow compare is done at ceil(log2(10**DIGITS))+1 bits to avoid truncation.
  - Nibbles never exceed 9 after correction.

Decomposition:
- Shared package display_pkg:
  - state enum {IDLE, SHIFT, FINISH}
  - DIGIT_W=4
  - BLANK_CODE=4'hF
  - DIGIT_MAX=4'h9
  - Shared with the seven-segment decoder so its default/blank branch and this block agree.
- Sub-module bcd_add3: combinational 4-bit in/out, adds 3 when input >= 5, instantiated DIGITS times per shift step.

Test Plan:
- Reset, then start with bin_in=305 (defaults) -> done exactly 12 clocks after the start edge; bcd_out=16'hF305; overflow=0; busy high for 12 cycles.
- bin_in=0 -> bcd_out=16'hFFF0.
- bin_in=2047 -> bcd_out=16'h2047.
- LZ_BLANK=0, bin_in=7 -> bcd_out=16'h0007.
- Start 42; pulse start with bin_in=999 at cycle 5 while busy -> single done; bcd_out=16'hFF42; the second start produces no further done.
- Start 1234; assert start with 56 in the done cycle -> second done 12 clocks later with bcd_out=16'hFF56; the first result (16'h1234) is held in between.
- BIN_W=14, start 12345 -> bcd_out=16'h9999, overflow=1.
- BIN_W=14, subsequent 9999 -> bcd_out=16'h9999, overflow=0.
- Drop rst_n at cycle 6 of converting 500 -> busy=0, bcd_out=16'hFFF0 immediately, no done.
- After release, start 8 -> bcd_out=16'hFFF8.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - digit codes and converter states shared with the seven-segment decoders
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int         DIGIT_W    = 4;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] DIGIT_MAX  = 4'h9;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble digit correction: add 3 when the nibble is 5 or more
module bcd_add3
    import display_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - one-bit-per-clock binary to BCD converter with leading-zero blanking
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int BIN_W    = 11,
    parameter int DIGITS   = 4,
    parameter int LZ_BLANK = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                      overflow
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int OVF_W = $clog2(10 ** DIGITS) + 1;
    localparam int CMP_W = (BIN_W > OVF_W) ? BIN_W : OVF_W;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;

    localparam logic [CMP_W-1:0] LIMIT = CMP_W'(10 ** DIGITS);

    function automatic logic [BCD_W-1:0] reset_bcd();
        logic [BCD_W-1:0] r;
        r = '0;
        if (LZ_BLANK != 0) begin
            for (int i = 1; i < DIGITS; i++) begin
                r[DIGIT_W*i +: DIGIT_W] = BLANK_CODE;
            end
        end
        return r;
    endfunction

    localparam logic [BCD_W-1:0] RST_BCD = reset_bcd();

    state_t             state, state_nxt;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_lat;
    logic [BCD_W-1:0]   result;
    logic               lead;

    // Binary bits pass through; each BCD nibble is corrected before the shift.
    assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (sr[BIN_W+DIGIT_W*g +: DIGIT_W]),
            .dout (sr_adj[BIN_W+DIGIT_W*g +: DIGIT_W])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Overflowed values clamp to all nines, so there is never a zero digit to blank.
    always_comb begin
        result = sr[SR_W-1 -: BCD_W];
        lead   = 1'b1;
        if (ovf_lat) begin
            result = {DIGITS{DIGIT_MAX}};
        end else if (LZ_BLANK != 0) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (result[DIGIT_W*i +: DIGIT_W] == '0)) begin
                    result[DIGIT_W*i +: DIGIT_W] = BLANK_CODE;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            ovf_lat  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= RST_BCD;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr      <= {{BCD_W{1'b0}}, bin_in};
                        cnt     <= '0;
                        ovf_lat <= (CMP_W'(bin_in) >= LIMIT);
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    sr  <= sr_adj << 1;
                    cnt <= cnt + CNT_W'(1);
                end
                FINISH: begin
                    bcd_out  <= result;
                    overflow <= ovf_lat;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0, s1, s2;
    logic [10:0] b0, b1;
    logic [13:0] b2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [15:0] bcd0, bcd1, bcd2;
    logic        ovf0, ovf1, ovf2;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(11), .DIGITS(4), .LZ_BLANK(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(s0), .bin_in(b0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .overflow(ovf0)
    );

    bin_to_bcd_seq #(.BIN_W(11), .DIGITS(4), .LZ_BLANK(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1), .bin_in(b1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .overflow(ovf1)
    );

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4), .LZ_BLANK(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(s2), .bin_in(b2),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
    );

    // Decimal digits by plain division, then blank leading zeros above the ones digit.
    function automatic logic [15:0] exp_bcd(input int v, input bit lz);
        logic [15:0] r;
        int          d;
        bit          lead;
        if (v >= 10000) return 16'h9999;
        r    = '0;
        lead = lz;
        for (int i = 3; i >= 0; i--) begin
            d = (v / (10 ** i)) % 10;
            if (lead && d == 0 && i > 0) begin
                r[4*i +: 4] = 4'hF;
            end else begin
                lead        = 1'b0;
                r[4*i +: 4] = 4'(d);
            end
        end
        return r;
    endfunction

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_bcd  = 16'hFFF0;
    int          m_left = 0;
    int          m_val  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_bcd  <= 16'hFFF0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_bcd  <= exp_bcd(m_val, 1'b1);
                    m_ovf  <= (m_val >= 10000);
                end
                m_left <= m_left - 1;
            end else if (s0) begin
                m_busy <= 1'b1;
                m_left <= 12;
                m_val  <= int'(b0);
            end
        end
    end

    always begin
        @(negedge clk);
        #1;
        checks++;
        if ({busy0, done0, bcd0, ovf0} !== {m_busy, m_done, m_bcd, m_ovf}) begin
            fails++;
            $display("FAIL cycle_model t=%0t got busy=%b done=%b bcd=%h ovf=%b required busy=%b done=%b bcd=%h ovf=%b",
                     $time, busy0, done0, bcd0, ovf0, m_busy, m_done, m_bcd, m_ovf);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", nm, got, exp);
        end
    endtask

    task automatic wait0(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done0 && lat < 40) begin
            if (busy0) bcnt++;
            tick();
            lat++;
        end
        chk("u0_done_timeout", 32'(lat < 40), 32'd1);
    endtask

    task automatic start0(input int v);
        s0 = 1'b1;
        b0 = 11'(v);
        tick();
        s0 = 1'b0;
    endtask

    task automatic count_done0(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done0) cnt++;
        end
    endtask

    int          lat, bcnt, nd;
    logic [15:0] rb;
    logic        ro;
    int          v1[4] = '{7, 0, 305, 2047};
    logic [15:0] e1[4] = '{16'h0007, 16'h0000, 16'h0305, 16'h2047};
    int          v2[4] = '{12345, 9999, 16383, 0};
    logic [15:0] e2[4] = '{16'h9999, 16'h9999, 16'h9999, 16'hFFF0};
    logic        o2[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b0;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        b0 = '0;   b1 = '0;   b2 = '0;
        repeat (3) tick();
        chk("reset_bcd0", 32'(bcd0), 32'hFFF0);
        chk("reset_bcd1", 32'(bcd1), 32'h0000);
        chk("reset_flags0", {29'd0, busy0, done0, ovf0}, 32'd0);
        rst_n = 1'b1;
        tick();

        start0(305);
        wait0(lat, bcnt);
        chk("lat_305", 32'(lat), 32'd12);
        chk("busy_cycles_305", 32'(bcnt), 32'd12);
        chk("bcd_305", 32'(bcd0), 32'hF305);
        chk("ovf_305", 32'(ovf0), 32'd0);
        tick();
        chk("done_one_cycle", 32'(done0), 32'd0);

        start0(0);
        wait0(lat, bcnt);
        chk("bcd_0", 32'(bcd0), 32'hFFF0);
        start0(2047);
        wait0(lat, bcnt);
        chk("bcd_2047", 32'(bcd0), 32'h2047);

        // A start pulse while busy must be ignored, not queued.
        start0(42);
        repeat (4) tick();
        s0 = 1'b1;
        b0 = 11'd999;
        tick();
        s0 = 1'b0;
        wait0(lat, bcnt);
        chk("lat_42_with_ignored_start", 32'(lat + 5), 32'd12);
        chk("bcd_42", 32'(bcd0), 32'hFF42);
        count_done0(20, nd);
        chk("no_extra_done", 32'(nd), 32'd0);

        // Back-to-back: restart in the done cycle.
        start0(1234);
        wait0(lat, bcnt);
        chk("bcd_1234", 32'(bcd0), 32'h1234);
        start0(56);
        chk("held_1234", 32'(bcd0), 32'h1234);
        wait0(lat, bcnt);
        chk("lat_b2b", 32'(lat), 32'd12);
        chk("bcd_56", 32'(bcd0), 32'hFF56);

        repeat (800) begin
            s0 = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       b0 = 11'd0;
                1:       b0 = 11'd2047;
                2:       b0 = 11'($urandom_range(0, 9));
                default: b0 = 11'($urandom);
            endcase
            tick();
        end
        s0 = 1'b0;
        repeat (15) tick();

        start0(500);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy0), 32'd0);
        chk("midreset_bcd", 32'(bcd0), 32'hFFF0);
        repeat (2) tick();
        rst_n = 1'b1;
        count_done0(15, nd);
        chk("midreset_no_done", 32'(nd), 32'd0);
        start0(8);
        wait0(lat, bcnt);
        chk("bcd_8", 32'(bcd0), 32'hFFF8);

        for (int k = 0; k < 4; k++) begin
            s1 = 1'b1;
            b1 = 11'(v1[k]);
            tick();
            s1 = 1'b0;
            lat = 0;
            while (!done1 && lat < 40) begin
                tick();
                lat++;
            end
            chk($sformatf("u1_lat_%0d", v1[k]), 32'(lat), 32'd12);
            chk($sformatf("u1_bcd_%0d", v1[k]), 32'(bcd1), 32'(e1[k]));
            chk($sformatf("u1_model_%0d", v1[k]), 32'(bcd1), 32'(exp_bcd(v1[k], 1'b0)));
        end

        for (int k = 0; k < 4; k++) begin
            s2 = 1'b1;
            b2 = 14'(v2[k]);
            tick();
            s2 = 1'b0;
            lat = 0;
            while (!done2 && lat < 40) begin
                tick();
                lat++;
            end
            rb = bcd2;
            ro = ovf2;
            chk($sformatf("u2_lat_%0d", v2[k]), 32'(lat), 32'd15);
            chk($sformatf("u2_bcd_%0d", v2[k]), 32'(rb), 32'(e2[k]));
            chk($sformatf("u2_ovf_%0d", v2[k]), 32'(ro), 32'(o2[k]));
            chk($sformatf("u2_model_%0d", v2[k]), 32'(rb), 32'(exp_bcd(v2[k], 1'b1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
